// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the register file and its scoreboard
package regfile_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_ZERO   = 0;
endpackage

// File: rtl/regfile_sb_popcount.sv
// regfile_sb_popcount: combinational population count of an N-bit vector
module regfile_sb_popcount #(
    parameter int N = 32
) (
    input  logic [N-1:0]             v,
    output logic [$clog2(N+1)-1:0]   cnt
);
    localparam int W = $clog2(N + 1);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) cnt = cnt + W'(v[i]);
    end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with busy-bit scoreboard and optional write bypass
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] RW,
    input  logic [DATA_W-1:0] busW,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              busyA,
    output logic              busyB,
    output logic [ADDR_W:0]   pend_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy, busy_nxt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              wr, iss, hit_a, hit_b;
    assign wr  = we && RW != ZERO;
    assign iss = iss_valid && iss_rd != ZERO;
    // issue is applied after the write clear so a new producer wins
    always_comb begin
        busy_nxt = busy;
        if (wr) busy_nxt[RW] = 1'b0;
        if (iss) busy_nxt[iss_rd] = 1'b1;
        busy_nxt[ZERO] = 1'b0;
        if (rst) busy_nxt = '0;
    end
    regfile_sb_popcount #(.N(DEPTH)) u_pop (.v(busy_nxt), .cnt(cnt_nxt));
    always_ff @(posedge clk) begin
        busy     <= busy_nxt;
        pend_cnt <= cnt_nxt;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr) begin
            regs[RW] <= busW;
        end
    end
    assign hit_a = BYPASS && we && RW == RA;
    assign hit_b = BYPASS && we && RW == RB;
    assign busA  = RA == ZERO ? '0 : hit_a ? busW : regs[RA];
    assign busB  = RB == ZERO ? '0 : hit_b ? busW : regs[RB];
    assign busyA = RA == ZERO ? 1'b0 : hit_a ? 1'b0 : busy[RA];
    assign busyB = RB == ZERO ? 1'b0 : hit_b ? 1'b0 : busy[RB];
endmodule
